// File: rtl/reg_file_wb.sv
// Architectural register file: WB write port, two registered ID read ports, combinational debug read.
// Latency: read data appears 1 cycle after capture; writes show on the debug port right after the edge.
// Backpressure: read_en_in=0 holds outputs; a write-back to a held index refreshes that port.
module reg_file_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs_addr_in,
  input  logic [ADDR_WIDTH-1:0] rt_addr_in,
  input  logic                  read_en_in,
  output logic [DATA_WIDTH-1:0] rs_data_out,
  output logic [DATA_WIDTH-1:0] rt_data_out,
  input  logic [DATA_WIDTH-1:0] wb_write_data_in,
  input  logic [ADDR_WIDTH-1:0] wb_write_addr_in,
  input  logic                  wb_reg_write_in,
  input  logic [ADDR_WIDTH-1:0] dbg_addr_in,
  output logic [DATA_WIDTH-1:0] dbg_data_out
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_rs_addr;
  logic [ADDR_WIDTH-1:0] r_rt_addr;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [DATA_WIDTH-1:0] r_rt_data;

  logic                  w_wr_qual;
  logic [DATA_WIDTH-1:0] w_rs_next;
  logic [DATA_WIDTH-1:0] w_rt_next;

  // Entry 0 is hard-wired to zero, so a write-back aimed at it is dropped here
  // regardless of what WB already filtered.
  assign w_wr_qual = wb_reg_write_in && (wb_write_addr_in != '0);

  // Port A next value: fresh read with bypass, or hold with refresh on a hit.
  always_comb begin
    w_rs_next = r_rs_data;
    if (read_en_in) begin
      if (rs_addr_in == '0)
        w_rs_next = '0;
      else if (w_wr_qual && (wb_write_addr_in == rs_addr_in))
        w_rs_next = wb_write_data_in;
      else
        w_rs_next = r_mem[rs_addr_in];
    end else if (w_wr_qual && (wb_write_addr_in == r_rs_addr)) begin
      // w_wr_qual already guarantees a non-zero index, so r0 never refreshes.
      w_rs_next = wb_write_data_in;
    end
  end

  // Port B next value: same rules as port A, independent of it.
  always_comb begin
    w_rt_next = r_rt_data;
    if (read_en_in) begin
      if (rt_addr_in == '0)
        w_rt_next = '0;
      else if (w_wr_qual && (wb_write_addr_in == rt_addr_in))
        w_rt_next = wb_write_data_in;
      else
        w_rt_next = r_mem[rt_addr_in];
    end else if (w_wr_qual && (wb_write_addr_in == r_rt_addr)) begin
      w_rt_next = wb_write_data_in;
    end
  end

  // Register array: cleared on reset, written on qualified write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr_qual) begin
      r_mem[wb_write_addr_in] <= wb_write_data_in;
    end
  end

  // Read-side state: latched indices only move on a capture, data every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rs_addr <= '0;
      r_rt_addr <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
    end else begin
      if (read_en_in) begin
        r_rs_addr <= rs_addr_in;
        r_rt_addr <= rt_addr_in;
      end
      r_rs_data <= w_rs_next;
      r_rt_data <= w_rt_next;
    end
  end

  assign rs_data_out  = r_rs_data;
  assign rt_data_out  = r_rt_data;
  // Debug sees the array only; the explicit zero keeps index 0 defined as 0.
  assign dbg_data_out = (dbg_addr_in == '0) ? '0 : r_mem[dbg_addr_in];

endmodule

// File: tb/tb_reg_file_wb.sv
module tb_reg_file_wb;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rs_addr_in, rt_addr_in, wb_write_addr_in, dbg_addr_in;
  logic          read_en_in, wb_reg_write_in;
  logic [DW-1:0] rs_data_out, rt_data_out, wb_write_data_in, dbg_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: architectural contents, expected outputs, held indices.
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] m_rs, m_rt;
  logic [AW-1:0] m_rsa, m_rta;

  reg_file_wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in), .read_en_in(read_en_in),
    .rs_data_out(rs_data_out), .rt_data_out(rt_data_out),
    .wb_write_data_in(wb_write_data_in), .wb_write_addr_in(wb_write_addr_in),
    .wb_reg_write_in(wb_reg_write_in),
    .dbg_addr_in(dbg_addr_in), .dbg_data_out(dbg_data_out)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    m_rs = '0; m_rt = '0; m_rsa = '0; m_rta = '0;
  endtask

  // Apply current inputs over one rising edge and advance the model; returns #1 after the edge.
  task automatic cycle();
    logic          wq;
    logic [DW-1:0] nrs, nrt;
    wq  = wb_reg_write_in && (wb_write_addr_in != 0);
    nrs = m_rs;
    nrt = m_rt;
    if (read_en_in) begin
      if (rs_addr_in == 0) nrs = '0;
      else if (wq && wb_write_addr_in == rs_addr_in) nrs = wb_write_data_in;
      else nrs = m_mem[rs_addr_in];
      if (rt_addr_in == 0) nrt = '0;
      else if (wq && wb_write_addr_in == rt_addr_in) nrt = wb_write_data_in;
      else nrt = m_mem[rt_addr_in];
      m_rsa = rs_addr_in;
      m_rta = rt_addr_in;
    end else begin
      if (wq && wb_write_addr_in == m_rsa) nrs = wb_write_data_in;
      if (wq && wb_write_addr_in == m_rta) nrt = wb_write_data_in;
    end
    if (wq) m_mem[wb_write_addr_in] = wb_write_data_in;
    m_rs = nrs;
    m_rt = nrt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_en_in = 1'b0; wb_reg_write_in = 1'b0;
    rs_addr_in = '0; rt_addr_in = '0; wb_write_addr_in = '0; wb_write_data_in = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    idle_inputs();
    wb_reg_write_in = 1'b1; wb_write_addr_in = a; wb_write_data_in = d;
    cycle();
    wb_reg_write_in = 1'b0;
  endtask

  task automatic test_reset();
    do_write(5'd3, 32'h3333_3333);
    do_write(5'd31, 32'h3131_3131);
    #2 rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    read_en_in = 1'b1; rs_addr_in = 5'd3; rt_addr_in = 5'd31;
    cycle();
    n_tests++;
    if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_read rs=%h rt=%h expected 0 0", rs_data_out, rt_data_out);
    end
    read_en_in = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_addr_in = i[AW-1:0];
      #1;
      n_tests++;
      if (dbg_data_out !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_dbg[%0d] got %h expected 0", i, dbg_data_out);
      end
    end
  endtask

  task automatic test_write_latency();
    dbg_addr_in = 5'd5;
    do_write(5'd5, 32'hDEAD_BEEF);
    n_tests++;
    if (dbg_data_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_dbg got %h expected deadbeef", dbg_data_out);
    end
    read_en_in = 1'b1; rs_addr_in = 5'd5; rt_addr_in = 5'd0;
    cycle();
    n_tests++;
    if (rs_data_out !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_read got %h expected deadbeef", rs_data_out);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd7, 32'h1111_1111);
    read_en_in = 1'b1; rs_addr_in = 5'd7; rt_addr_in = 5'd7;
    wb_reg_write_in = 1'b1; wb_write_addr_in = 5'd7; wb_write_data_in = 32'h2222_2222;
    cycle();
    n_tests++;
    if (rs_data_out !== 32'h2222_2222 || rt_data_out !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL bypass rs=%h rt=%h expected 22222222", rs_data_out, rt_data_out);
    end
  endtask

  task automatic test_r0();
    dbg_addr_in = 5'd0;
    idle_inputs();
    read_en_in = 1'b1; rs_addr_in = 5'd0; rt_addr_in = 5'd7;
    wb_reg_write_in = 1'b1; wb_write_addr_in = 5'd0; wb_write_data_in = 32'hFFFF_FFFF;
    cycle();
    n_tests++;
    if (dbg_data_out !== 32'h0 || rs_data_out !== 32'h0 || rt_data_out !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL r0_same dbg=%h rs=%h rt=%h expected 0 0 22222222",
               dbg_data_out, rs_data_out, rt_data_out);
    end
    wb_reg_write_in = 1'b0;
    cycle();
    n_tests++;
    if (rs_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL r0_read got %h expected 0", rs_data_out);
    end
  endtask

  task automatic test_stall_refresh();
    do_write(5'd9, 32'hA);
    do_write(5'd4, 32'hB);
    read_en_in = 1'b1; rs_addr_in = 5'd9; rt_addr_in = 5'd4;
    cycle();
    read_en_in = 1'b0; rs_addr_in = 5'd12;
    wb_reg_write_in = 1'b1; wb_write_addr_in = 5'd9; wb_write_data_in = 32'hC;
    cycle();
    n_tests++;
    if (rs_data_out !== 32'hC || rt_data_out !== 32'hB) begin
      n_fail++;
      $display("FAIL stall_refresh rs=%h rt=%h expected c b", rs_data_out, rt_data_out);
    end
    wb_write_addr_in = 5'd12; wb_write_data_in = 32'hD;
    cycle();
    wb_reg_write_in = 1'b0;
    n_tests++;
    if (rs_data_out !== 32'hC || rt_data_out !== 32'hB) begin
      n_fail++;
      $display("FAIL stall_other rs=%h rt=%h expected c b", rs_data_out, rt_data_out);
    end
  endtask

  task automatic test_reset_mid_stall();
    // Outputs currently hold 0xC / 0xB with read_en_in=0.
    #2 rst_n = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_stall rs=%h rt=%h expected 0 0", rs_data_out, rt_data_out);
    end
    dbg_addr_in = 5'd9;
    #1;
    n_tests++;
    if (dbg_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_stall_dbg got %h expected 0", dbg_data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      read_en_in       = ($urandom_range(0, 9) < 7);
      rs_addr_in       = AW'($urandom_range(0, 7));
      rt_addr_in       = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      wb_reg_write_in  = ($urandom_range(0, 1) == 1);
      wb_write_addr_in = AW'($urandom_range(0, 7));
      wb_write_data_in = $urandom;
      dbg_addr_in      = AW'($urandom_range(0, 7));
      cycle();
      n_tests++;
      if (rs_data_out !== m_rs || rt_data_out !== m_rt || dbg_data_out !== m_mem[dbg_addr_in]) begin
        n_fail++;
        $display("FAIL random[%0d] rs=%h/%h rt=%h/%h dbg=%h/%h", n,
                 rs_data_out, m_rs, rt_data_out, m_rt, dbg_data_out, m_mem[dbg_addr_in]);
      end
    end
    wb_reg_write_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    dbg_addr_in = '0;
    model_clear();
    #12 rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (rs_data_out !== 32'h0 || rt_data_out !== 32'h0 || dbg_data_out !== 32'h0) begin
      n_fail++;
      $display("FAIL por rs=%h rt=%h dbg=%h expected 0", rs_data_out, rt_data_out, dbg_data_out);
    end
    test_reset();
    test_write_latency();
    test_bypass();
    test_r0();
    test_stall_refresh();
    test_reset_mid_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
